// File: rtl/mem_io_bridge.sv
// Memory/IO stage for the 16-bit multicycle processor: word RAM, LED/HEX registers,
// and an output FIFO drained over valid/ready, with a single registered read path.
module mem_io_bridge #(
  parameter int RAM_AW  = 7,
  parameter int FIFO_AW = 3
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] DIN,
  output logic [15:0] LEDR,
  output logic [15:0] HEX,
  output logic [15:0] fifo_data,
  output logic        fifo_valid,
  input  logic        fifo_ready
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [15:0]        ram      [2**RAM_AW];
  logic [15:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               ovf;

  logic [3:0]  region;
  logic        ram_sel, led_sel, hex_sel, fifo_sel, stat_sel;
  logic        full, empty, push, pop, do_push, ovf_set;
  logic [15:0] status;
  logic [15:0] rd_mux;

  assign region   = ADDR[15:12];
  assign ram_sel  = (region == 4'h0);
  assign led_sel  = (region == 4'h1);
  assign hex_sel  = (region == 4'h2);
  assign fifo_sel = (region == 4'h3) && !ADDR[0];
  assign stat_sel = (region == 4'h3) && ADDR[0];

  assign full    = (count == (FIFO_AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push    = W && fifo_sel;
  assign pop     = fifo_valid && fifo_ready;
  // A push into a full FIFO only lands if a pop frees the slot on the same edge.
  assign do_push = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  assign fifo_valid = !empty;
  assign fifo_data  = fifo_mem[rd_ptr];

  always_comb begin
    status      = '0;
    status[15]  = ovf;
    status[5]   = full;
    status[4]   = empty;
    status[3:0] = 4'(count);
  end

  always_comb begin
    rd_mux = '0;
    if (ram_sel)       rd_mux = ram[ADDR[RAM_AW-1:0]];
    else if (led_sel)  rd_mux = LEDR;
    else if (hex_sel)  rd_mux = HEX;
    else if (stat_sel) rd_mux = status;
  end

  // Storage arrays: no reset; RAM reads see pre-edge contents (old data on collision).
  always_ff @(posedge Clock) begin
    if (W && ram_sel) ram[ADDR[RAM_AW-1:0]] <= DOUT;
    if (do_push)      fifo_mem[wr_ptr]      <= DOUT;
  end

  // Read stage and control state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      DIN    <= '0;
      LEDR   <= '0;
      HEX    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      DIN <= rd_mux;
      if (W && led_sel) LEDR <= DOUT;
      if (W && hex_sel) HEX  <= DOUT;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)       ovf <= 1'b1;
      else if (stat_sel) ovf <= 1'b0;
    end
  end

endmodule
